// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | text_buffer_ctrl: 32-byte LCD character buffer, cursor, clear/scroll |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module text_buffer_ctrl #(
  parameter logic [7:0] BLANK     = 8'h20,
  parameter logic       SCROLL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] mem_addr,
  output logic [7:0] mem_bus,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [4:0] cursor,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_FF = 8'h0C;

  state_t     r_state;
  logic [4:0] r_cnt;
  logic [7:0] r_buf [32];
  logic       w_accept;
  logic       w_printable;

  assign w_accept    = char_valid & char_ready;
  assign w_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign mem_bus     = r_buf[mem_addr];
  assign busy        = ~char_ready;

  // Buffer has no reset: CLEAR initialises it after every reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= 5'd0;
      cursor     <= 5'd0;
      char_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_buf[r_cnt] <= BLANK;
          r_cnt        <= r_cnt + 5'd1;
          cursor       <= 5'd0;
          if (r_cnt == 5'd31) begin
            r_state    <= ST_IDLE;
            char_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_buf[cursor] <= char_in;
              if (cursor != 5'd31) begin
                cursor <= cursor + 5'd1;
              end else if (SCROLL_EN) begin
                r_state    <= ST_SCROLL;
                r_cnt      <= 5'd0;
                cursor     <= 5'd16;
                char_ready <= 1'b0;
              end else begin
                cursor <= 5'd0;
              end
            end else if (char_in == C_BS) begin
              if (cursor != 5'd0) begin
                cursor                <= cursor - 5'd1;
                r_buf[cursor - 5'd1]  <= BLANK;
              end
            end else if (char_in == C_CR) begin
              if (!cursor[4]) begin
                cursor <= 5'd16;
              end else if (SCROLL_EN) begin
                r_state    <= ST_SCROLL;
                r_cnt      <= 5'd0;
                cursor     <= 5'd16;
                char_ready <= 1'b0;
              end else begin
                cursor <= 5'd0;
              end
            end else if (char_in == C_FF) begin
              r_state    <= ST_CLEAR;
              r_cnt      <= 5'd0;
              cursor     <= 5'd0;
              char_ready <= 1'b0;
            end
          end
        end
        ST_SCROLL: begin
          r_buf[{1'b0, r_cnt[3:0]}] <= r_buf[{1'b1, r_cnt[3:0]}];
          r_buf[{1'b1, r_cnt[3:0]}] <= BLANK;
          r_cnt                     <= r_cnt + 5'd1;
          if (r_cnt[3:0] == 4'd15) begin
            r_state    <= ST_IDLE;
            char_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_cnt      <= 5'd0;
          cursor     <= 5'd0;
          char_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_text_buffer_ctrl: scroll and wrap variants against a buffer model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] mem_addr;
  logic [7:0] char_in;
  logic       char_valid;
  logic [7:0] bus0, bus1;
  logic       rdy0, rdy1, busy0, busy1;
  logic [4:0] cur0, cur1;

  int checks = 0;
  int fails  = 0;

  // Index 0 models SCROLL_EN=1, index 1 models SCROLL_EN=0.
  logic [7:0] m_buf [2][32];
  int         m_cur [2];

  always #5 clk = ~clk;

  text_buffer_ctrl #(.BLANK(8'h20), .SCROLL_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_bus(bus0),
    .char_in(char_in), .char_valid(char_valid), .char_ready(rdy0),
    .cursor(cur0), .busy(busy0)
  );

  text_buffer_ctrl #(.BLANK(8'h20), .SCROLL_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_bus(bus1),
    .char_in(char_in), .char_valid(char_valid), .char_ready(rdy1),
    .cursor(cur1), .busy(busy1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input int w);
    for (int i = 0; i < 32; i++) m_buf[w][i] = 8'h20;
    m_cur[w] = 0;
  endtask

  // Return value: number of stall cycles the command should cause.
  task automatic model_apply(input int w, input logic [7:0] c, output int stall);
    bit se;
    se = (w == 0);
    stall = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_buf[w][m_cur[w]] = c;
      if (m_cur[w] < 31) m_cur[w] = m_cur[w] + 1;
      else if (se) begin
        for (int i = 0; i < 16; i++) begin
          m_buf[w][i]      = m_buf[w][i + 16];
          m_buf[w][i + 16] = 8'h20;
        end
        m_cur[w] = 16;
        stall = 16;
      end else m_cur[w] = 0;
    end else if (c == 8'h08) begin
      if (m_cur[w] > 0) begin
        m_cur[w] = m_cur[w] - 1;
        m_buf[w][m_cur[w]] = 8'h20;
      end
    end else if (c == 8'h0D) begin
      if (m_cur[w] < 16) m_cur[w] = 16;
      else if (se) begin
        for (int i = 0; i < 16; i++) begin
          m_buf[w][i]      = m_buf[w][i + 16];
          m_buf[w][i + 16] = 8'h20;
        end
        m_cur[w] = 16;
        stall = 16;
      end else m_cur[w] = 0;
    end else if (c == 8'h0C) begin
      model_clear(w);
      stall = 32;
    end
  endtask

  task automatic check_buffer(input string tag);
    for (int a = 0; a < 32; a++) begin
      mem_addr = 5'(a);
      #1;
      checks++;
      if (bus0 !== m_buf[0][a]) begin
        fails++;
        $display("FAIL %s buf0[%0d] got %h exp %h", tag, a, bus0, m_buf[0][a]);
      end
      checks++;
      if (bus1 !== m_buf[1][a]) begin
        fails++;
        $display("FAIL %s buf1[%0d] got %h exp %h", tag, a, bus1, m_buf[1][a]);
      end
    end
  endtask

  task automatic check_cursor(input string tag);
    checks++;
    if (cur0 !== 5'(m_cur[0])) begin
      fails++;
      $display("FAIL %s cursor0 got %0d exp %0d", tag, cur0, m_cur[0]);
    end
    checks++;
    if (cur1 !== 5'(m_cur[1])) begin
      fails++;
      $display("FAIL %s cursor1 got %0d exp %0d", tag, cur1, m_cur[1]);
    end
  endtask

  // Present one character when both instances are ready, then measure stalls.
  task automatic send(input logic [7:0] c, input string tag);
    int n, s0, s1, n0, n1;
    n = 0;
    while (!(rdy0 && rdy1) && n < 200) begin step; n++; end
    if (!(rdy0 && rdy1)) begin
      checks++; fails++;
      $display("FAIL %s ready_timeout got %b%b exp 11", tag, rdy0, rdy1);
    end
    char_in = c;
    char_valid = 1'b1;
    step;
    char_valid = 1'b0;
    char_in = 8'($urandom);
    model_apply(0, c, s0);
    model_apply(1, c, s1);
    n0 = -1; n1 = -1;
    for (int k = 0; k <= 100; k++) begin
      if (n0 < 0 && rdy0) n0 = k;
      if (n1 < 0 && rdy1) n1 = k;
      checks++;
      if (busy0 !== ~rdy0) begin
        fails++;
        $display("FAIL %s busy0 got %b exp %b", tag, busy0, ~rdy0);
      end
      if (n0 >= 0 && n1 >= 0) break;
      step;
    end
    checks++;
    if (n0 != s0) begin
      fails++;
      $display("FAIL %s stall0 got %0d exp %0d", tag, n0, s0);
    end
    checks++;
    if (n1 != s1) begin
      fails++;
      $display("FAIL %s stall1 got %0d exp %0d", tag, n1, s1);
    end
    check_cursor(tag);
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (3) step;
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b%b busy %b%b exp 00 busy 11", rdy0, rdy1, busy0, busy1);
    end
    checks++;
    if (cur0 !== 5'd0 || cur1 !== 5'd0) begin
      fails++;
      $display("FAIL reset_cursor got %0d/%0d exp 0", cur0, cur1);
    end
    rst_n = 1'b1;
    n = 0;
    while (!rdy0 && n < 100) begin step; n++; end
    checks++;
    if (n != 32 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_clear_len got %0d exp 32", n);
    end
    model_clear(0);
    model_clear(1);
    check_buffer("reset_blank");
    check_cursor("reset_cursor_after");
  endtask

  task automatic test_back_to_back;
    int s;
    char_in = 8'h41;
    char_valid = 1'b1;
    step;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready got %b%b exp 11", rdy0, rdy1);
    end
    char_in = 8'h42;
    step;
    char_valid = 1'b0;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready2 got %b%b exp 11", rdy0, rdy1);
    end
    for (int w = 0; w < 2; w++) begin
      model_apply(w, 8'h41, s);
      model_apply(w, 8'h42, s);
    end
    check_cursor("b2b_cursor");
    check_buffer("b2b_buf");
  endtask

  task automatic test_fill_scroll;
    send(8'h0C, "fill_ff");
    for (int i = 0; i < 32; i++) send(8'(8'h41 + i), "fill_char");
    check_buffer("fill_buf");
  endtask

  task automatic test_backspace;
    send(8'h0C, "bs_ff");
    send(8'h61, "bs_a");
    send(8'h62, "bs_b");
    send(8'h63, "bs_c");
    send(8'h08, "bs_at3");
    check_buffer("bs_buf");
    send(8'h0C, "bs_ff2");
    send(8'h08, "bs_at0");
    check_buffer("bs0_buf");
  endtask

  task automatic test_enter;
    send(8'h0C, "cr_ff");
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), "cr_row0");
    send(8'h0D, "cr_at5");
    for (int i = 0; i < 4; i++) send(8'(8'h70 + i), "cr_row1");
    send(8'h0D, "cr_at20");
    send(8'h07, "cr_bell");
    check_buffer("cr_buf");
  endtask

  task automatic test_random;
    int r;
    logic [7:0] c;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) c = 8'($urandom_range(8'h20, 8'h7E));
      else if (r == 6) c = 8'h08;
      else if (r == 7) c = 8'h0D;
      else if ($urandom_range(0, 3) == 0) c = 8'h0C;
      else c = 8'($urandom_range(128, 255));
      send(c, "rand");
    end
    check_buffer("rand_buf");
  endtask

  task automatic test_ff_reset;
    int n;
    send(8'h0C, "ffr_ff");
    send(8'h48, "ffr_h");
    send(8'h49, "ffr_i");
    char_in = 8'h0C;
    char_valid = 1'b1;
    step;
    char_valid = 1'b0;
    repeat (10) step;
    checks++;
    if (rdy0 !== 1'b0) begin
      fails++;
      $display("FAIL ffr_midclear_ready got %b exp 0", rdy0);
    end
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    n = 0;
    while (!rdy0 && n < 100) begin step; n++; end
    checks++;
    if (n != 32) begin
      fails++;
      $display("FAIL ffr_clear_len got %0d exp 32", n);
    end
    model_clear(0);
    model_clear(1);
    check_buffer("ffr_buf");
    check_cursor("ffr_cursor");
  endtask

  initial begin
    rst_n = 1'b0;
    char_in = 8'h00;
    char_valid = 1'b0;
    mem_addr = 5'd0;
    test_reset;
    test_back_to_back;
    test_fill_scroll;
    test_backspace;
    test_enter;
    test_random;
    test_ff_reset;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
